// File: rtl/ariane_soc.sv
// SoC-wide constants shared by the crossbar and its default (error) slave.
package ariane_soc;

   // ID width seen by slaves behind the crossbar (master ID plus port select bits)
   localparam int unsigned IdWidthSlave = 5;

   // AXI decode-error response code
   localparam logic [1:0] AxiRespDecErr = 2'b11;

   // Recognisable filler returned on every read beat of an unmapped access
   localparam logic [63:0] ErrSlvRespData = 64'hBADC_AB1E_BADC_AB1E;

endpackage

// File: rtl/ariane_soc_err_slv_if.sv
// Reduced AXI4 channel bundle for the error slave: only the fields the
// responder consumes or produces are carried.
interface ariane_soc_err_slv_if #(
   parameter int unsigned IdWidth   = ariane_soc::IdWidthSlave,
   parameter int unsigned DataWidth = 64
);
   // write address
   logic                 aw_valid_i;
   logic                 aw_ready_o;
   logic [IdWidth-1:0]   aw_id_i;
   // write data
   logic                 w_valid_i;
   logic                 w_ready_o;
   logic                 w_last_i;
   // write response
   logic                 b_valid_o;
   logic                 b_ready_i;
   logic [IdWidth-1:0]   b_id_o;
   logic [1:0]           b_resp_o;
   // read address
   logic                 ar_valid_i;
   logic                 ar_ready_o;
   logic [IdWidth-1:0]   ar_id_i;
   logic [7:0]           ar_len_i;
   // read data
   logic                 r_valid_o;
   logic                 r_ready_i;
   logic [IdWidth-1:0]   r_id_o;
   logic [DataWidth-1:0] r_data_o;
   logic [1:0]           r_resp_o;
   logic                 r_last_o;

   // the error responder
   modport slave (
      input  aw_valid_i, aw_id_i, w_valid_i, w_last_i, b_ready_i,
             ar_valid_i, ar_id_i, ar_len_i, r_ready_i,
      output aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
             ar_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
   );

   // the crossbar side driving requests
   modport master (
      output aw_valid_i, aw_id_i, w_valid_i, w_last_i, b_ready_i,
             ar_valid_i, ar_id_i, ar_len_i, r_ready_i,
      input  aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
             ar_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
   );
endinterface

// File: rtl/ariane_soc_err_slv_rd.sv
// Read-side burst generator of the error slave: accepts one AR, then emits
// ar_len+1 DECERR beats carrying the filler pattern.
module ariane_soc_err_slv_rd
   import ariane_soc::*;
#(
   parameter int unsigned IdWidth   = IdWidthSlave,
   parameter int unsigned DataWidth = 64,
   parameter logic [63:0] RespData  = ErrSlvRespData
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ar_valid_i,
   output logic                 ar_ready_o,
   input  logic [IdWidth-1:0]   ar_id_i,
   input  logic [7:0]           ar_len_i,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic [IdWidth-1:0]   r_id_o,
   output logic [DataWidth-1:0] r_data_o,
   output logic [1:0]           r_resp_o,
   output logic                 r_last_o
);

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

   r_state_e           r_state_q, r_state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [IdWidth-1:0] id_q, id_d;

   // state, remaining-beat counter and captured ID
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state_q <= R_IDLE;
         cnt_q     <= 8'd0;
         id_q      <= '0;
      end else begin
         r_state_q <= r_state_d;
         cnt_q     <= cnt_d;
         id_q      <= id_d;
      end
   end

   // next state: capture AR, count beats down, leave on the final beat
   always_comb begin
      r_state_d = r_state_q;
      cnt_d     = cnt_q;
      id_d      = id_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_valid_i) begin
               id_d      = ar_id_i;
               cnt_d     = ar_len_i;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (r_ready_i) begin
               // counter stops at zero; the zero-count beat is the last one
               if (cnt_q == 8'd0) begin
                  r_state_d = R_IDLE;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // outputs depend on registers only, so payload is stable while stalled
   assign ar_ready_o = (r_state_q == R_IDLE);
   assign r_valid_o  = (r_state_q == R_DATA);
   assign r_id_o     = id_q;
   assign r_data_o   = (r_state_q == R_DATA) ? RespData[DataWidth-1:0] : '0;
   assign r_resp_o   = (r_state_q == R_DATA) ? AxiRespDecErr : 2'b00;
   assign r_last_o   = (r_state_q == R_DATA) && (cnt_q == 8'd0);

endmodule

// File: rtl/ariane_soc_err_slv.sv
// Default slave of the ariane_soc crossbar: terminates every unmapped access
// with DECERR. Write path is handled inline, read bursts in the _rd submodule.
module ariane_soc_err_slv
   import ariane_soc::*;
#(
   parameter int unsigned IdWidth   = IdWidthSlave,
   parameter int unsigned DataWidth = 64,
   parameter logic [63:0] RespData  = ErrSlvRespData
) (
   input  logic               clk_i,
   input  logic               rst_i,
   ariane_soc_err_slv_if.slave bus
);

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   w_state_e           w_state_q, w_state_d;
   logic [IdWidth-1:0] w_id_q, w_id_d;

   // write FSM state and the AW ID echoed back on B
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
      end
   end

   // write next state: AW, then sink W until w_last, then hold B until taken
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      case (w_state_q)
         W_IDLE: begin
            if (bus.aw_valid_i) begin
               w_id_d    = bus.aw_id_i;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            // burst length from AW is not tracked; w_last alone ends the burst
            if (bus.w_valid_i && bus.w_last_i) begin
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (bus.b_ready_i) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // write-side outputs decoded from registers only
   assign bus.aw_ready_o = (w_state_q == W_IDLE);
   assign bus.w_ready_o  = (w_state_q == W_DATA);
   assign bus.b_valid_o  = (w_state_q == W_RESP);
   assign bus.b_id_o     = w_id_q;
   assign bus.b_resp_o   = (w_state_q == W_RESP) ? AxiRespDecErr : 2'b00;

   ariane_soc_err_slv_rd #(
      .IdWidth   (IdWidth),
      .DataWidth (DataWidth),
      .RespData  (RespData)
   ) i_rd (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .ar_valid_i (bus.ar_valid_i),
      .ar_ready_o (bus.ar_ready_o),
      .ar_id_i    (bus.ar_id_i),
      .ar_len_i   (bus.ar_len_i),
      .r_valid_o  (bus.r_valid_o),
      .r_ready_i  (bus.r_ready_i),
      .r_id_o     (bus.r_id_o),
      .r_data_o   (bus.r_data_o),
      .r_resp_o   (bus.r_resp_o),
      .r_last_o   (bus.r_last_o)
   );

endmodule

// File: tb/tb_ariane_soc_err_slv.sv
// Bench for the ariane_soc error slave: directed transaction table, corner
// sequences (concurrency, early W, mid-burst reset) and a randomized phase
// checked against a transaction-level queue model.
module tb_ariane_soc_err_slv;
   import ariane_soc::*;

   localparam int unsigned IW = IdWidthSlave;
   localparam int unsigned DW = 64;
   localparam logic [63:0] EXP_DATA = 64'hBADC_AB1E_BADC_AB1E;
   localparam logic [1:0]  DECERR   = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ariane_soc_err_slv_if #(.IdWidth(IW), .DataWidth(DW)) bus ();

   ariane_soc_err_slv #(.IdWidth(IW), .DataWidth(DW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed transaction table ----------------
   typedef struct {
      bit is_rd;
      int id;
      int len;       // AR len, or number of W beats minus one
      int bp;        // cycles the response channel is held not-ready
      int exp_lat;   // cycles from A handshake to first response valid
      int exp_beats; // expected response beats
   } vec_t;

   vec_t vecs[7];

   task automatic run_txn(input vec_t v, input int idx);
      int lat;
      int beats;
      int guard;
      bit done;
      if (!v.is_rd) begin
         bus.aw_valid_i = 1'b1;
         bus.aw_id_i    = IW'(v.id);
         check("wr aw_ready idle", bus.aw_ready_o, 1);
         step();
         bus.aw_valid_i = 1'b0;
         lat = 1;
         check("wr w_ready after AW", bus.w_ready_o, 1);
         check("wr aw_ready busy", bus.aw_ready_o, 0);
         for (int b = 0; b <= v.len; b++) begin
            bus.w_valid_i = 1'b1;
            bus.w_last_i  = (b == v.len);
            check("wr w_ready in burst", bus.w_ready_o, 1);
            check("wr no early b_valid", bus.b_valid_o, 0);
            step();
            lat++;
         end
         bus.w_valid_i = 1'b0;
         bus.w_last_i  = 1'b0;
         guard = 0;
         while (!bus.b_valid_o && guard < 10) begin
            step();
            lat++;
            guard++;
         end
         check("wr B latency", lat, v.exp_lat);
         for (int c = 0; c < v.bp; c++) begin
            check("wr b_valid held", bus.b_valid_o, 1);
            check("wr b_id held", bus.b_id_o, v.id);
            check("wr aw_ready stall", bus.aw_ready_o, 0);
            step();
         end
         bus.b_ready_i = 1'b1;
         check("wr b_valid", bus.b_valid_o, 1);
         check("wr b_id", bus.b_id_o, v.id);
         check("wr b_resp", bus.b_resp_o, DECERR);
         step();
         bus.b_ready_i = 1'b0;
         check("wr b_valid after B", bus.b_valid_o, 0);
         check("wr aw_ready after B", bus.aw_ready_o, 1);
         $display("txn %0d: write id=%0d beats=%0d lat=%0d", idx, v.id, v.len + 1, lat);
      end else begin
         bus.ar_valid_i = 1'b1;
         bus.ar_id_i    = IW'(v.id);
         bus.ar_len_i   = 8'(v.len);
         check("rd ar_ready idle", bus.ar_ready_o, 1);
         step();
         bus.ar_valid_i = 1'b0;
         lat = 1;
         guard = 0;
         while (!bus.r_valid_o && guard < 10) begin
            step();
            lat++;
            guard++;
         end
         check("rd first beat latency", lat, v.exp_lat);
         for (int c = 0; c < v.bp; c++) begin
            bus.r_ready_i = 1'b0;
            check("rd r_valid held", bus.r_valid_o, 1);
            check("rd r_data held", bus.r_data_o, EXP_DATA);
            check("rd r_last held", bus.r_last_o, v.len == 0);
            step();
         end
         bus.r_ready_i = 1'b1;
         beats = 0;
         guard = 0;
         done  = 1'b0;
         while (!done && guard < 600) begin
            guard++;
            if (bus.r_valid_o) begin
               check("rd r_data", bus.r_data_o, EXP_DATA);
               check("rd r_resp", bus.r_resp_o, DECERR);
               check("rd r_id", bus.r_id_o, v.id);
               check("rd r_last position", bus.r_last_o, beats == v.exp_beats - 1);
               check("rd ar_ready busy", bus.ar_ready_o, 0);
               if (bus.r_last_o) done = 1'b1;
               beats++;
            end
            step();
         end
         bus.r_ready_i = 1'b0;
         check("rd beat count", beats, v.exp_beats);
         check("rd r_valid after last", bus.r_valid_o, 0);
         check("rd ar_ready after last", bus.ar_ready_o, 1);
         $display("txn %0d: read id=%0d len=%0d beats=%0d", idx, v.id, v.len, beats);
      end
   endtask

   // ---------------- randomized phase: transaction-level model ----------------
   typedef struct {
      int id;
      bit last;
   } rbeat_t;

   int     exp_b[$];
   rbeat_t exp_r[$];
   bit     mon_en  = 1'b0;
   bit     pb_pend = 1'b0;
   bit     pr_pend = 1'b0;
   int     pb_id, pr_id;
   bit     pr_last;

   // observe handshakes between edges; every AW yields one B, every AR len+1 beats
   always @(negedge clk) begin
      if (mon_en) begin
         int     eb;
         rbeat_t er;
         if (pb_pend) begin
            check("B valid stable", bus.b_valid_o, 1);
            check("B id stable", bus.b_id_o, pb_id);
         end
         if (pr_pend) begin
            check("R valid stable", bus.r_valid_o, 1);
            check("R id stable", bus.r_id_o, pr_id);
            check("R last stable", bus.r_last_o, pr_last);
            check("R data stable", bus.r_data_o, EXP_DATA);
         end
         if (bus.aw_valid_i && bus.aw_ready_o) exp_b.push_back(int'(bus.aw_id_i));
         if (bus.ar_valid_i && bus.ar_ready_o) begin
            for (int k = 0; k <= int'(bus.ar_len_i); k++)
               exp_r.push_back('{int'(bus.ar_id_i), k == int'(bus.ar_len_i)});
         end
         if (bus.b_valid_o && bus.b_ready_i) begin
            if (exp_b.size() == 0) begin
               check("B without AW", 1, 0);
            end else begin
               eb = exp_b.pop_front();
               check("rand b_id", bus.b_id_o, eb);
               check("rand b_resp", bus.b_resp_o, DECERR);
            end
         end
         if (bus.r_valid_o && bus.r_ready_i) begin
            if (exp_r.size() == 0) begin
               check("R without AR", 1, 0);
            end else begin
               er = exp_r.pop_front();
               check("rand r_id", bus.r_id_o, er.id);
               check("rand r_last", bus.r_last_o, er.last);
               check("rand r_data", bus.r_data_o, EXP_DATA);
               check("rand r_resp", bus.r_resp_o, DECERR);
            end
         end
         pb_pend = bus.b_valid_o && !bus.b_ready_i;
         pb_id   = int'(bus.b_id_o);
         pr_pend = bus.r_valid_o && !bus.r_ready_i;
         pr_id   = int'(bus.r_id_o);
         pr_last = bus.r_last_o;
      end
   end

   task automatic wr_master(input int n);
      int id;
      int nb;
      int sent;
      int guard;
      bit hs;
      for (int i = 0; i < n; i++) begin
         id = int'($urandom_range(0, 31));
         nb = int'($urandom_range(1, 4));
         repeat ($urandom_range(0, 2)) step();
         bus.aw_valid_i = 1'b1;
         bus.aw_id_i    = IW'(id);
         guard = 0;
         do begin
            hs = bus.aw_ready_o;
            step();
            guard++;
         end while (!hs && guard < 50);
         bus.aw_valid_i = 1'b0;
         if (!hs) check("rand AW accept timeout", 0, 1);
         sent  = 0;
         guard = 0;
         while (sent < nb && guard < 100) begin
            bus.w_valid_i = ($urandom % 2) != 0;
            bus.w_last_i  = (sent == nb - 1);
            hs = bus.w_valid_i && bus.w_ready_o;
            step();
            if (hs) sent++;
            guard++;
         end
         bus.w_valid_i = 1'b0;
         bus.w_last_i  = 1'b0;
         if (sent != nb) check("rand W accept timeout", sent, nb);
         guard = 0;
         do begin
            bus.b_ready_i = ($urandom % 2) != 0;
            hs = bus.b_valid_o && bus.b_ready_i;
            step();
            guard++;
         end while (!hs && guard < 100);
         bus.b_ready_i = 1'b0;
         if (!hs) check("rand B timeout", 0, 1);
         $display("rand write %0d: id=%0d beats=%0d", i, id, nb);
      end
   endtask

   task automatic rd_master(input int n);
      int id;
      int len;
      int guard;
      bit hs;
      for (int i = 0; i < n; i++) begin
         id  = int'($urandom_range(0, 31));
         len = (i == 0) ? 255 : int'($urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) step();
         bus.ar_valid_i = 1'b1;
         bus.ar_id_i    = IW'(id);
         bus.ar_len_i   = 8'(len);
         guard = 0;
         do begin
            hs = bus.ar_ready_o;
            step();
            guard++;
         end while (!hs && guard < 50);
         bus.ar_valid_i = 1'b0;
         if (!hs) check("rand AR accept timeout", 0, 1);
         guard = 0;
         do begin
            bus.r_ready_i = ($urandom % 2) != 0;
            hs = bus.r_valid_o && bus.r_ready_i && bus.r_last_o;
            step();
            guard++;
         end while (!hs && guard < 2000);
         bus.r_ready_i = 1'b0;
         if (!hs) check("rand R last timeout", 0, 1);
         $display("rand read %0d: id=%0d len=%0d", i, id, len);
      end
   endtask

   // watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0,  5,   0, 0, 2,   1};
      vecs[1] = '{1'b0,  9,   3, 5, 5,   1};
      vecs[2] = '{1'b1,  2,   3, 0, 1,   4};
      vecs[3] = '{1'b1,  7,   0, 3, 1,   1};
      vecs[4] = '{1'b1, 31,  15, 2, 1,  16};
      vecs[5] = '{1'b0, 31,   1, 2, 3,   1};
      vecs[6] = '{1'b1, 12, 255, 0, 1, 256};

      bus.aw_valid_i = 1'b0; bus.aw_id_i = '0;
      bus.w_valid_i  = 1'b0; bus.w_last_i = 1'b0;
      bus.b_ready_i  = 1'b0;
      bus.ar_valid_i = 1'b0; bus.ar_id_i = '0; bus.ar_len_i = '0;
      bus.r_ready_i  = 1'b0;

      // reset state
      rst = 1'b1;
      step();
      check("reset aw_ready", bus.aw_ready_o, 1);
      check("reset ar_ready", bus.ar_ready_o, 1);
      check("reset w_ready", bus.w_ready_o, 0);
      check("reset b_valid", bus.b_valid_o, 0);
      check("reset r_valid", bus.r_valid_o, 0);
      check("reset r_last", bus.r_last_o, 0);
      check("reset b_id", bus.b_id_o, 0);
      check("reset r_id", bus.r_id_o, 0);
      check("reset r_data", bus.r_data_o, 0);
      check("reset b_resp", bus.b_resp_o, 0);
      check("reset r_resp", bus.r_resp_o, 0);
      step();
      rst = 1'b0;
      step();
      check("post-reset aw_ready", bus.aw_ready_o, 1);
      check("post-reset ar_ready", bus.ar_ready_o, 1);

      // directed table
      for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

      // early W stalls, then AW and AR accepted together
      bus.w_valid_i = 1'b1;
      bus.w_last_i  = 1'b1;
      check("early W stalled", bus.w_ready_o, 0);
      step();
      check("early W still stalled", bus.w_ready_o, 0);
      step();
      bus.aw_valid_i = 1'b1; bus.aw_id_i = IW'(10);
      bus.ar_valid_i = 1'b1; bus.ar_id_i = IW'(3); bus.ar_len_i = 8'd1;
      check("conc aw_ready", bus.aw_ready_o, 1);
      check("conc ar_ready", bus.ar_ready_o, 1);
      step();
      bus.aw_valid_i = 1'b0;
      bus.ar_valid_i = 1'b0;
      check("conc w_ready", bus.w_ready_o, 1);
      check("conc r_valid", bus.r_valid_o, 1);
      check("conc r_id", bus.r_id_o, 3);
      check("conc r_last beat0", bus.r_last_o, 0);
      check("conc b_valid early", bus.b_valid_o, 0);
      bus.r_ready_i = 1'b1;
      step();
      bus.w_valid_i = 1'b0;
      bus.w_last_i  = 1'b0;
      check("conc b_valid", bus.b_valid_o, 1);
      check("conc b_id", bus.b_id_o, 10);
      check("conc b_resp", bus.b_resp_o, DECERR);
      check("conc r_valid beat1", bus.r_valid_o, 1);
      check("conc r_last beat1", bus.r_last_o, 1);
      bus.b_ready_i = 1'b1;
      step();
      bus.b_ready_i = 1'b0;
      bus.r_ready_i = 1'b0;
      check("conc b_valid done", bus.b_valid_o, 0);
      check("conc r_valid done", bus.r_valid_o, 0);
      check("conc aw_ready done", bus.aw_ready_o, 1);
      check("conc ar_ready done", bus.ar_ready_o, 1);
      $display("txn concurrent: write id=10 and read id=3 len=1");

      // reset during W_DATA and during beat 2 of a len=7 read
      bus.aw_valid_i = 1'b1; bus.aw_id_i = IW'(4);
      bus.ar_valid_i = 1'b1; bus.ar_id_i = IW'(6); bus.ar_len_i = 8'd7;
      step();
      bus.aw_valid_i = 1'b0;
      bus.ar_valid_i = 1'b0;
      bus.r_ready_i  = 1'b1;
      check("rstseq w_ready", bus.w_ready_o, 1);
      step();
      check("rstseq beat2 valid", bus.r_valid_o, 1);
      check("rstseq beat2 last", bus.r_last_o, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.r_ready_i = 1'b0;
      check("rstseq r_valid", bus.r_valid_o, 0);
      check("rstseq w_ready", bus.w_ready_o, 0);
      check("rstseq aw_ready", bus.aw_ready_o, 1);
      check("rstseq ar_ready", bus.ar_ready_o, 1);
      check("rstseq b_valid", bus.b_valid_o, 0);
      step();
      check("rstseq dropped r_valid", bus.r_valid_o, 0);
      check("rstseq dropped b_valid", bus.b_valid_o, 0);
      $display("txn reset: in-flight write id=4 and read id=6 dropped");
      run_txn(vecs[2], 7);

      // randomized traffic on both channels
      pb_pend = 1'b0;
      pr_pend = 1'b0;
      mon_en  = 1'b1;
      fork
         wr_master(20);
         rd_master(12);
      join
      repeat (3) step();
      mon_en = 1'b0;
      check("rand B queue drained", exp_b.size(), 0);
      check("rand R queue drained", exp_r.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
